// File: rtl/vector_reduce_pkg.sv
// vector_reduce_pkg: mode/op enums and latency helper shared by the reduce unit and its tree.
package vector_reduce_pkg;
  typedef enum logic [1:0] {MODE_PASS, MODE_SUM, MODE_GROUP, MODE_MAX} mode_t;
  typedef enum logic {OP_SUM, OP_MAX} op_t;
  function automatic int reduce_latency(int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/vector_reduce_tree.sv
// reduce_tree: pipelined pairwise sum/signed-max tree exposing every level; lvl[0] is the raw input.
module reduce_tree
  import vector_reduce_pkg::*;
#(
  parameter int  N          = 8,
  parameter int  DATA_WIDTH = 32,
  parameter op_t OP         = OP_SUM
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        valid,
  input  logic [N-1:0][DATA_WIDTH-1:0]                data,
  output logic [$clog2(N):0][N-1:0][DATA_WIDTH-1:0]   lvl,
  output logic [$clog2(N):0]                          vld
);
  localparam int L = $clog2(N);
  assign lvl[0] = data;
  assign vld[0] = valid;
  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int C = N >> k;
    logic [C-1:0][DATA_WIDTH-1:0] q;
    logic v;
    // ties keep the left (lower-index) operand
    always_ff @(posedge clk) begin
      v <= rst ? 1'b0 : vld[k-1];
      if (vld[k-1])
        for (int i = 0; i < C; i++)
          q[i] <= OP == OP_MAX
            ? ($signed(lvl[k-1][2*i]) >= $signed(lvl[k-1][2*i+1]) ? lvl[k-1][2*i] : lvl[k-1][2*i+1])
            : lvl[k-1][2*i] + lvl[k-1][2*i+1];
    end
    assign lvl[k] = (N*DATA_WIDTH)'(q);
    assign vld[k] = v;
  end
endmodule

// File: rtl/vector_reduce_unit.sv
// vector_reduce_unit: per-chain pass/sum/group-sum/max reduction, fixed latency, one vector per cycle.
// Define VECTOR_REDUCE_MAX_EN to build the signed-max mode (code 3); otherwise code 3 passes through.
module vector_reduce_unit
  import vector_reduce_pkg::*;
#(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int M                  = 2,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  localparam int CW = MAX_CHAINS > 1 ? $clog2(MAX_CHAINS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]  vector_in,
  input  logic [1:0]                    eof_in,
  input  logic [1:0]                    bof_in,
  input  logic [CW-1:0]                 chainId_in,
  input  logic                          tracing,
  input  logic [7:0]                    configId,
  input  logic [7:0]                    configData,
  output logic                          valid_out,
  output logic [N-1:0][DATA_WIDTH-1:0]  vector_out,
  output logic [1:0]                    eof_out,
  output logic [1:0]                    bof_out,
  output logic [CW-1:0]                 chainId_out
);
  localparam int L = reduce_latency(N) - 1;
  localparam int G = $clog2(N / M);
  localparam int D = L - G;
`ifdef VECTOR_REDUCE_MAX_EN
  localparam bit MAX_EN = 1'b1;
`else
  localparam bit MAX_EN = 1'b0;
`endif
  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;
  logic [7:0] fw [MAX_CHAINS];
  logic [7:0] byte_counter;
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_counter <= '0;
      for (int i = 0; i < MAX_CHAINS; i++) fw[i] <= '0;
    end else if (!tracing) begin
      if (configId == 8'(PERSONAL_CONFIG_ID)) begin
        for (int i = 0; i < MAX_CHAINS; i++) if (32'(byte_counter) == i) fw[i] <= configData;
        if (byte_counter != 8'hff) byte_counter <= byte_counter + 8'd1;
      end else byte_counter <= '0;
    end
  end
  logic accept;
  logic [7:0] code;
  mode_t mode_in;
  assign accept = valid_in & tracing;
  assign code = fw[chainId_in];
  always_comb
    mode_in = code == 8'd1 ? MODE_SUM : code == 8'd2 ? MODE_GROUP :
              (code == 8'd3 && MAX_EN) ? MODE_MAX : MODE_PASS;
  logic [L:0][N-1:0][DATA_WIDTH-1:0] sum_lvl;
  logic [L:0] vld;
  logic unused_bits;
  vec_t max_res;
  reduce_tree #(.N(N), .DATA_WIDTH(DATA_WIDTH), .OP(OP_SUM)) u_sum (
    .clk(clk), .rst(rst), .valid(accept), .data(vector_in), .lvl(sum_lvl), .vld(vld)
  );
`ifdef VECTOR_REDUCE_MAX_EN
  logic [L:0][N-1:0][DATA_WIDTH-1:0] max_lvl;
  logic [L:0] max_vld;
  reduce_tree #(.N(N), .DATA_WIDTH(DATA_WIDTH), .OP(OP_MAX)) u_max (
    .clk(clk), .rst(rst), .valid(accept), .data(vector_in), .lvl(max_lvl), .vld(max_vld)
  );
  assign max_res = max_lvl[L];
  assign unused_bits = ^{sum_lvl, vld, max_lvl, max_vld};
`else
  assign max_res = '0;
  assign unused_bits = ^{sum_lvl, vld};
`endif
  // mode and pass-through data ride alongside the tree, stage k paired with vld[k]
  mode_t mode_q [L];
  vec_t pass_q [L];
  logic [CW+3:0] sb_q [L];
  always_ff @(posedge clk) begin
    if (vld[0]) begin
      mode_q[0] <= mode_in;
      pass_q[0] <= vector_in;
    end
    for (int k = 1; k < L; k++)
      if (vld[k]) begin
        mode_q[k] <= mode_q[k-1];
        pass_q[k] <= pass_q[k-1];
      end
    sb_q[0] <= rst ? '0 : {eof_in, bof_in, chainId_in};
    for (int k = 1; k < L; k++) sb_q[k] <= rst ? '0 : sb_q[k-1];
  end
  vec_t grp;
  if (D > 0) begin : g_grp
    vec_t q [D];
    always_ff @(posedge clk) begin
      if (vld[G]) q[0] <= sum_lvl[G];
      for (int j = 1; j < D; j++) if (vld[G+j]) q[j] <= q[j-1];
    end
    assign grp = q[D-1];
  end else begin : g_grp_direct
    assign grp = sum_lvl[L];
  end
  vec_t res;
  always_comb
    res = mode_q[L-1] == MODE_SUM ? sum_lvl[L] :
          mode_q[L-1] == MODE_GROUP ? grp :
          mode_q[L-1] == MODE_MAX ? max_res : pass_q[L-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      vector_out <= '0;
      {eof_out, bof_out, chainId_out} <= '0;
    end else begin
      valid_out <= vld[L];
      {eof_out, bof_out, chainId_out} <= sb_q[L-1];
      if (vld[L]) vector_out <= res;
    end
  end
endmodule

// File: doc/vector_reduce_unit.md
# vector_reduce_unit

Successor to the fixed-function reduce stage in the trace instrumentation pipeline. Reduces an N-lane vector per chain to N values (pass-through), M group sums, one total sum, or one signed maximum; each chain selects its mode through byte-serial firmware. The reduction tree is fully pipelined, so the block accepts one vector per cycle. It sits between the filter/match stages and the data packer, and carries the eof/bof/chainId sideband alongside each vector.

## Interface
Parameters:
- N, 8: vector lanes; power of two, ≥2
- DATA_WIDTH, 32: lane width, two's complement
- M, 2: group count for group-sum mode; power of two, 1 ≤ M ≤ N
- MAX_CHAINS, 4: firmware entries, one per chain
- PERSONAL_CONFIG_ID, 0: configId this block responds to

Ports:
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  reset, synchronous, active-high
- valid_in  in  1  input vector valid
- vector_in  in  N×DATA_WIDTH  input lanes
- eof_in  in  2  end-of-frame sideband
- bof_in  in  2  begin-of-frame sideband
- chainId_in  in  clog2(MAX_CHAINS)  chain tag; indexes the firmware
- tracing  in  1  1 = operate, 0 = configure
- configId  in  8  configuration target id
- configData  in  8  configuration byte
- valid_out  out  1  output valid
- vector_out  out  N×DATA_WIDTH  result lanes
- eof_out, bof_out  out  2  delayed sideband
- chainId_out  out  clog2(MAX_CHAINS)  delayed chain tag

## Operation
- Firmware modes, one byte per chain:
  - 0 = pass-through.
  - 1 = total sum in lane 0; all other lanes 0.
  - 2 = group sums. Lane g (g < M) holds the sum of lanes g·N/M … (g+1)·N/M−1; lanes ≥ M are 0.
  - 3 = signed max in lane 0; other lanes 0.
  - Any other code is treated as pass-through.
- The mode is looked up from firmware[chainId_in] at input acceptance and travels down the pipeline with the data. A firmware change never affects in-flight vectors.
- Arithmetic: sums wrap modulo 2^DATA_WIDTH with no saturation. Max uses a signed compare; on ties, the lowest-index lane is returned.
- Group sums are tapped from adder-tree level clog2(N/M), then delayed to align with the final stage. M=1 makes mode 2 equal to mode 1; M=N makes it equal to mode 0.
- Configuration applies when tracing=0:
  - When configId==PERSONAL_CONFIG_ID, each cycle writes configData to firmware[byte_counter] if byte_counter < MAX_CHAINS, then increments byte_counter. Bytes beyond MAX_CHAINS are ignored.
  - byte_counter saturates at 255.
  - Any other configId clears byte_counter.
  - With tracing=1, byte_counter holds its value.
- With tracing=0, valid_in is masked to 0 at the pipeline input. Vectors already in flight drain normally.
- Reset:
  - valid_out=0, vector_out all 0, eof_out=bof_out=0, chainId_out=0.
  - All pipeline valids are cleared.
  - byte_counter=0 and every firmware entry is 0 (pass-through).
  - A reset mid-stream discards all in-flight vectors.

## Timing
- Fixed latency LAT = clog2(N)+1 cycles, from valid_in sampled to valid_out, for every mode.
- Throughput is one vector per cycle. There is no backpressure and no stall.
- Sideband (eof, bof, chainId) is delayed by exactly LAT cycles whether valid or not. valid_out marks when the data is meaningful.
- Data registers load only on valid stages; when invalid, vector_out holds its last value.
- A firmware write in cycle t affects vectors accepted in cycle t+1 or later.
- If rst and a config write occur in the same cycle, rst wins.

## Configuration
- VECTOR_REDUCE_MAX_EN
  - Defined: mode 3 (signed max) is built, including the comparator tree.
  - Undefined: no comparator tree is built, and code 3 decodes as pass-through. All other behaviour and LAT are unchanged.

## Structure
- Package vector_reduce_pkg:
  - Mode enum: MODE_PASS, MODE_SUM, MODE_GROUP, MODE_MAX.
  - Function reduce_latency(N), returning clog2(N)+1.
- Sub-module reduce_tree, parametrised by N, DATA_WIDTH and OP (sum or max).
  - Registered per level, with a valid chain.
  - Exposes per-level outputs for the group-sum tap.
- reduce_tree is instantiated once for sum and, when VECTOR_REDUCE_MAX_EN is defined, once for max.

## Test plan
Bench parameters: N=8, DATA_WIDTH=32, M=2, MAX_CHAINS=4, ID=0, so LAT=4.
- Config load: tracing=0, configId=0, bytes 0,1,2,3,9 on consecutive cycles -> firmware={0,1,2,3}; the 5th byte is ignored. configId=5 for one cycle, then byte 7 -> firmware[0]=7 (decodes as pass-through).
- Sum: chain 1, vector {1..8} -> 4 cycles later lane0=36, lanes 1–7=0, chainId_out=1, eof/bof aligned. Eight lanes of 0x7FFFFFFF -> lane0=0xFFFFFFF8.
- Group: chain 2, vector {1..8} -> lane0=10, lane1=26, rest 0.
- Max: chain 3, vector {-5,3,7,-1,0,2,7,1} -> lane0=7. Built without the macro -> output equals the input.
- Streaming: 16 back-to-back vectors cycling chains 0–3, with the firmware rewritten mid-stream via a tracing drop -> 16 outputs in order, each reduced with the mode captured at its own acceptance.
- Reset mid-stream: rst asserted while 3 vectors are in flight -> the next cycle shows valid_out=0 with no late outputs, and chain 1 now passes vectors through unchanged.
